// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU sequencing types: FSM state encoding, register-control bundle and MDU constants.
// Combinational definitions only; no handshake involved.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MDU  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 4;

  // Enables then clears for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_clr;
    logic idex_clr;
    logic exmem_clr;
    logic memwb_clr;
  } ctl_t;

  localparam ctl_t CTL_DEF    = ctl_t'(9'b11111_0000);
  localparam ctl_t CTL_LDUSE  = ctl_t'(9'b00111_0100);
  localparam ctl_t CTL_FLUSH  = ctl_t'(9'b11111_1100);
  localparam ctl_t CTL_MDU    = ctl_t'(9'b00011_0010);
  localparam ctl_t CTL_HLT_IN = ctl_t'(9'b00000_0001);
  localparam ctl_t CTL_OFF    = ctl_t'(9'b00000_0000);
  localparam ctl_t CTL_RST    = ctl_t'(9'b00000_1111);

  // Busy-counter preload: entry cycle plus preload+1 busy cycles equals MDU_LAT
  function automatic logic [3:0] mdu_init(input int lat);
    return 4'(lat - 2);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle; slave is the controller, master is the pipeline side.
// Plain level signals, no flow control.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             wb_halt;
  logic             go;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
           ex_branch_taken, ex_mdu_start, wb_halt, go,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           halted, stall_cnt, flush_cnt, cycle_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
           ex_branch_taken, ex_mdu_start, wb_halt, go,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           halted, stall_cnt, flush_cnt, cycle_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: load in EX writing a register the ID instruction reads.
// Purely combinational, zero latency.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_rs_used_i,
  input  logic       id_rt_used_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                      ((id_rs_used_i && (id_rs_i == ex_rd_i)) ||
                       (id_rt_used_i && (id_rt_i == ex_rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing FSM (RUN/MDU_BUSY/HALT) driving register enables/clears, plus perf counters.
// Enables/clears are same-cycle combinational; state and counters update on the next edge.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               clear_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam bit              MDU_MULTI = (MDU_LAT > 1);
  localparam logic [3:0]      MDU_INIT  = mdu_init(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [3:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, cycle_cnt_q;
  logic             stall_inc, flush_inc, cyc_inc;
  logic             load_use;
  logic             halted;
  ctl_t             ctl;

  hazard_detect u_hazard_detect (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_rs_used_i  (bus.id_rs_used),
    .id_rt_used_i  (bus.id_rt_used),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rd_i       (bus.ex_rd),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    mdu_cnt_d = mdu_cnt_q;
    ctl       = CTL_DEF;
    halted    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    cyc_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        cyc_inc = 1'b1;
        if (bus.wb_halt) begin
          ctl     = CTL_HLT_IN;
          ret_d   = ST_RUN;
          state_d = ST_HALT;
        end else if (bus.ex_mdu_start && MDU_MULTI) begin
          ctl       = CTL_MDU;
          mdu_cnt_d = MDU_INIT;
          state_d   = ST_MDU;
          stall_inc = 1'b1;
        end else if (bus.ex_branch_taken) begin
          // A coincident load-use is moot: its ID instruction is being flushed
          ctl       = CTL_FLUSH;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ctl       = CTL_LDUSE;
          stall_inc = 1'b1;
        end
      end
      ST_MDU: begin
        cyc_inc = 1'b1;
        if (bus.wb_halt) begin
          ctl     = CTL_HLT_IN;
          ret_d   = ST_MDU;
          state_d = ST_HALT;
        end else if (mdu_cnt_q != 4'd0) begin
          ctl       = CTL_MDU;
          mdu_cnt_d = mdu_cnt_q - 4'd1;
          stall_inc = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        ctl    = CTL_OFF;
        halted = 1'b1;
        if (bus.go) state_d = ret_q;
      end
      default: state_d = ST_RUN;
    endcase
    // Reset overrides every state so the pipeline registers flush while held
    if (!clear_n) begin
      ctl    = CTL_RST;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      mdu_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      mdu_cnt_q <= mdu_cnt_d;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      if (cyc_inc)   cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
    end
  end

  assign bus.pc_en     = ctl.pc_en;
  assign bus.ifid_en   = ctl.ifid_en;
  assign bus.idex_en   = ctl.idex_en;
  assign bus.exmem_en  = ctl.exmem_en;
  assign bus.memwb_en  = ctl.memwb_en;
  assign bus.ifid_clr  = ctl.ifid_clr;
  assign bus.idex_clr  = ctl.idex_clr;
  assign bus.exmem_clr = ctl.exmem_clr;
  assign bus.memwb_clr = ctl.memwb_clr;
  assign bus.halted    = halted;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the four 32-bit pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register of the 5-stage CPU.
- Drives each register's enable and clear inputs to implement:
  - load-use stalls
  - branch flushes
  - multi-cycle MUL/DIV residency in EX
  - syscall halt/resume
- Keeps 32-bit performance counters for the debug display.

Parameters:
MDU_LAT, 4, cycles a MUL/DIV occupies EX (legal range 1..15; 1 means no stall)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, all state on rising edge
clear_n  in  1  reset: one clock; reset is synchronous and active-low
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  destination register of EX instruction
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_mdu_start  in  1  EX holds MUL/DIV in its first EX cycle
wb_halt  in  1  syscall-halt instruction in WB
go  in  1  resume pulse from front panel
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  register clears (bubble insert)
halted  out  1  CPU is in HALT state
stall_cnt  out  CNT_W  cycles lost to load-use and MDU stalls
flush_cnt  out  CNT_W  taken-branch flush events
cycle_cnt  out  CNT_W  non-halted cycles since reset

Behaviour:
- Enable/clear outputs are combinational from state and inputs. State and counters are registered.
- Default (no event): all *_en=1, all *_clr=0.
- Definition: load_use = ex_mem_read & (ex_rd!=0) & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- FSM states: RUN, MDU_BUSY, HALT. Registers: ret_state (RUN/MDU_BUSY) and mdu_cnt (4 bits).
- Priority within a cycle: wb_halt > MDU > ex_branch_taken > load_use.
- RUN:
  - wb_halt: all *_en=0, memwb_clr=1 (syscall retires once). ret_state<=RUN. Next state HALT.
  - Else ex_mdu_start with MDU_LAT>1: pc_en=ifid_en=idex_en=0, exmem_clr=1, memwb_en=1. mdu_cnt<=MDU_LAT-2. Next state MDU_BUSY. stall_cnt+1.
  - Else ex_branch_taken: all en=1, ifid_clr=idex_clr=1. flush_cnt+1. load_use in the same cycle is ignored (its ID instruction is flushed).
  - Else load_use: pc_en=ifid_en=0, idex_clr=1, others enabled. stall_cnt+1.
  - With MDU_LAT=1, ex_mdu_start is ignored.
- MDU_BUSY:
  - Same freeze pattern as the MDU entry cycle. stall_cnt+1 per cycle.
  - mdu_cnt!=0: mdu_cnt-1, stay in MDU_BUSY.
  - mdu_cnt==0: instead drive default outputs (the MDU result advances) and return to RUN. This cycle does not count as a stall.
  - MUL/DIV total EX residency is MDU_LAT cycles. ex_branch_taken, load_use and ex_mdu_start are ignored in this state.
  - wb_halt: all *_en=0, memwb_clr=1, ret_state<=MDU_BUSY, mdu_cnt frozen, next state HALT.
- HALT:
  - All *_en=0, *_clr=0, halted=1. cycle_cnt frozen. wb_halt ignored.
  - go=1: next state is ret_state, with mdu_cnt intact. Outputs stay frozen during the go cycle itself.
  - go outside HALT is ignored.
- Counters: increment by 1 and wrap at 2^CNT_W. cycle_cnt increments in every RUN and MDU_BUSY cycle.
- Reset (clear_n=0 sampled at a clock edge):
  - state<=RUN, ret_state<=RUN, mdu_cnt<=0, all counters<=0.
  - While clear_n=0 the combinational outputs are forced: all *_en=0, all *_clr=1, halted=0. This overrides every state, including mid-MDU and HALT.
  - The first cycle after release is plain RUN.

Decomposition:
- Shared CPU package holds:
  - state encoding constants ST_RUN=2'd0, ST_MDU=2'd1, ST_HALT=2'd2
  - REG_ZERO=5'd0
  - default MDU_LAT
- One sub-module, hazard_detect: purely combinational load_use compare, reused by the forwarding unit.
- FSM, MDU counter and perf counters stay in the top module.

Test Plan:
- Reset: hold clear_n=0 for 3 clocks in mid-HALT → halted=0, all *_clr=1, *_en=0. After release: state RUN, all counters 0, default outputs.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_rs_used=1 → pc_en=ifid_en=0, idex_clr=1 for exactly one cycle; stall_cnt=1. Same with ex_rd=0 → no stall.
- Branch plus load-use in the same cycle → ifid_clr=idex_clr=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- MDU, MDU_LAT=4: ex_mdu_start pulse → pc_en/ifid_en/idex_en low and exmem_clr high for 3 cycles, default outputs on the 4th; stall_cnt=3. With MDU_LAT=1 → no stall.
- Halt during MDU (wb_halt in 2nd busy cycle) → memwb_clr=1 that cycle, then halted=1 and all en=0 for 10 cycles, cycle_cnt frozen. After go: 1 more busy cycle, then the release cycle.
- Counter wrap: CNT_W=4, drive 16 load-use stalls → stall_cnt returns to 0.
